// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: one-hot opcode bit positions,
// controller state encoding and the opcode legality check.
package alu_pkg;

  localparam int OP_BITS = 12;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_ROR = 6;
  localparam int OP_ROL = 7;
  localparam int OP_AND = 8;
  localparam int OP_OR  = 9;
  localparam int OP_NEG = 10;
  localparam int OP_NOT = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Exactly one opcode bit set: clearing the lowest set bit must leave nothing.
  function automatic logic onehot_ok(input logic [OP_BITS-1:0] c);
    return (c != '0) && ((c & (c - 12'd1)) == '0);
  endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide on
// operand magnitudes, one bit per clock, sharing a single adder.
module seq_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             run;
  logic             div_mode;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   mul_next;
  logic             trial_ok;

  // Divide mode subtracts the divisor from the shifted partial remainder;
  // the top carry is then "no borrow". Multiply mode adds the multiplicand.
  always_comb begin
    if (div_mode) begin
      add_a   = {hi, lo[WIDTH-1]};
      add_b   = ~{1'b0, operand};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi};
      add_b   = {1'b0, operand};
      add_cin = 1'b0;
    end
    sum      = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
    trial_ok = sum[WIDTH+1];
    mul_next = lo[0] ? sum[WIDTH:0] : {1'b0, hi};
  end

  assign last = run && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      run      <= 1'b0;
      div_mode <= 1'b0;
      cnt      <= '0;
      operand  <= '0;
      hi       <= '0;
      lo       <= '0;
    end else if (load) begin
      run      <= 1'b1;
      div_mode <= is_div;
      cnt      <= '0;
      operand  <= opb;
      hi       <= '0;
      lo       <= opa;
    end else if (run) begin
      cnt <= cnt + 1'b1;
      run <= !last;
      if (div_mode) begin
        hi <= trial_ok ? sum[WIDTH-1:0] : {hi[WIDTH-2:0], lo[WIDTH-1]};
        lo <= {lo[WIDTH-2:0], trial_ok};
      end else begin
        {hi, lo} <= {mul_next, lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU between the A/B operand registers and ZHI/ZLO: single-cycle
// logic/shift/add ops, iterative signed or unsigned multiply and divide.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter bit SIGNED_MULDIV = 1'b1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [OP_BITS-1:0] CONTROL,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   ZLO,
  output logic [WIDTH-1:0]   ZHI,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               illegal_op
);

  localparam int SW = $clog2(WIDTH);

  state_t             state;
  logic [OP_BITS-1:0] op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               pend;
  logic               neg_q;
  logic               neg_r;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               go_iter;
  logic               core_load;
  logic               core_last;
  logic [WIDTH-1:0]   core_hi;
  logic [WIDTH-1:0]   core_lo;

  // Only a legal mul, or a div with a non-zero divisor, needs the iterative core.
  always_comb begin
    a_neg     = SIGNED_MULDIV && A[WIDTH-1];
    b_neg     = SIGNED_MULDIV && B[WIDTH-1];
    a_mag     = a_neg ? -A : A;
    b_mag     = b_neg ? -B : B;
    go_iter   = onehot_ok(CONTROL) &&
                (CONTROL[OP_MUL] || (CONTROL[OP_DIV] && (B != '0)));
    core_load = (state == IDLE) && start && go_iter;
  end

  seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .clr    (clr),
    .load   (core_load),
    .is_div (CONTROL[OP_DIV]),
    .opa    (a_mag),
    .opb    (b_mag),
    .last   (core_last),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  logic [SW-1:0]    amt;
  logic [SW:0]      amt_c;
  logic             shift_big;
  logic [WIDTH-1:0] one_res;

  // WIDTH is a power of two, so B >= WIDTH is any bit above the amount field.
  always_comb begin
    amt       = b_q[SW-1:0];
    amt_c     = (SW+1)'(WIDTH) - {1'b0, amt};
    shift_big = |b_q[WIDTH-1:SW];
    one_res   = '0;
    if (op_q[OP_ADD])      one_res = a_q + b_q;
    else if (op_q[OP_SUB]) one_res = a_q - b_q;
    else if (op_q[OP_NEG]) one_res = '0 - a_q;
    else if (op_q[OP_NOT]) one_res = ~a_q;
    else if (op_q[OP_AND]) one_res = a_q & b_q;
    else if (op_q[OP_OR])  one_res = a_q | b_q;
    else if (op_q[OP_SHL]) one_res = shift_big ? '0 : (a_q << amt);
    else if (op_q[OP_SHR]) one_res = shift_big ? '0 : (a_q >> amt);
    else if (op_q[OP_ROL]) one_res = (a_q << amt) | (a_q >> amt_c);
    else if (op_q[OP_ROR]) one_res = (a_q >> amt) | (a_q << amt_c);
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  // Quotient/product take the XOR of operand signs; remainder follows the dividend.
  always_comb begin
    prod = {core_hi, core_lo};
    if (neg_q) prod = -prod;
    quo = neg_q ? -core_lo : core_lo;
    rem = neg_r ? -core_hi : core_hi;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      pend        <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      ZLO         <= '0;
      ZHI         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            done <= 1'b1;
            if (!onehot_ok(op_q)) begin
              illegal_op  <= 1'b1;
              div_by_zero <= 1'b0;
            end else if (op_q[OP_DIV]) begin
              ZLO         <= '1;
              ZHI         <= a_q;
              div_by_zero <= 1'b1;
              illegal_op  <= 1'b0;
            end else begin
              ZLO         <= one_res;
              ZHI         <= '0;
              div_by_zero <= 1'b0;
              illegal_op  <= 1'b0;
            end
          end
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            op_q  <= CONTROL;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (go_iter) begin
              state <= ITER;
              busy  <= 1'b1;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        ITER: begin
          if (core_last) state <= FIX;
        end
        FIX: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          illegal_op  <= 1'b0;
          if (op_q[OP_MUL]) begin
            ZHI <= prod[2*WIDTH-1:WIDTH];
            ZLO <= prod[WIDTH-1:0];
          end else begin
            ZHI <= rem;
            ZLO <= quo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32, signed mul/div): a
// spec-level model checked every cycle plus hand-computed directed vectors.
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic [11:0]  control;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] zlo;
  logic [W-1:0] zhi;
  logic         busy;
  logic         done;
  logic         dbz;
  logic         ill;

  multicycle_alu #(.WIDTH(W), .SIGNED_MULDIV(1'b1)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .CONTROL     (control),
    .A           (a_in),
    .B           (b_in),
    .ZLO         (zlo),
    .ZHI         (zhi),
    .busy        (busy),
    .done        (done),
    .div_by_zero (dbz),
    .illegal_op  (ill)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Result of one operation straight from the arithmetic rules.
  function automatic void modelOp(input logic [11:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi,
                                  output bit dz, output bit il, output bit keep, output bit lng);
    longint sa, sb, p, q, r;
    logic [W-1:0] x;
    int amt;
    lo = '0; hi = '0; dz = 0; il = 0; keep = 0; lng = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    amt = int'(b % 32);
    x = a;
    if ($countones(c) != 1) begin
      il = 1; keep = 1;
    end else if (c[OP_ADD]) lo = a + b;
    else if (c[OP_SUB]) lo = a - b;
    else if (c[OP_NEG]) lo = -a;
    else if (c[OP_NOT]) lo = ~a;
    else if (c[OP_AND]) lo = a & b;
    else if (c[OP_OR])  lo = a | b;
    else if (c[OP_SHL]) lo = (b >= 32) ? '0 : a << b;
    else if (c[OP_SHR]) lo = (b >= 32) ? '0 : a >> b;
    else if (c[OP_ROL]) begin
      for (int i = 0; i < amt; i++) x = {x[W-2:0], x[W-1]};
      lo = x;
    end else if (c[OP_ROR]) begin
      for (int i = 0; i < amt; i++) x = {x[0], x[W-1:1]};
      lo = x;
    end else if (c[OP_MUL]) begin
      p = sa * sb;
      lo = p[W-1:0]; hi = p[2*W-1:W]; lng = 1;
    end else if (c[OP_DIV]) begin
      if (b == '0) begin
        lo = '1; hi = a; dz = 1;
      end else begin
        q = sa / sb; r = sa % sb;
        lo = q[W-1:0]; hi = r[W-1:0]; lng = 1;
      end
    end
  endfunction

  logic [W-1:0] m_zlo, m_zhi, s_lo, s_hi;
  bit m_dbz, m_ill, m_done, m_busy, model_ready = 0;
  bit s_valid, s_long, s_keep, s_dbz, s_ill, busy_before;
  int s_edge, edge_no = 0;

  // Model: at most one operation in flight; completion is resolved before a new acceptance.
  always @(posedge clk) begin
    edge_no++;
    if (clr) begin
      s_valid = 0; m_zlo = '0; m_zhi = '0; m_dbz = 0; m_ill = 0;
      m_done = 0; m_busy = 0; model_ready = 1;
    end else begin
      busy_before = s_valid && s_long;
      m_done = 0;
      if (s_valid && s_edge == edge_no) begin
        if (!s_keep) begin m_zlo = s_lo; m_zhi = s_hi; end
        m_dbz = s_dbz; m_ill = s_ill; m_done = 1; s_valid = 0;
      end
      if (start && !busy_before) begin
        modelOp(control, a_in, b_in, s_lo, s_hi, s_dbz, s_ill, s_keep, s_long);
        s_valid = 1;
        s_edge = edge_no + (s_long ? W + 1 : 1);
      end
      m_busy = s_valid && s_long;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput($sformatf("e%0d done", edge_no), W'(done), W'(m_done));
      checkOutput($sformatf("e%0d busy", edge_no), W'(busy), W'(m_busy));
      checkOutput($sformatf("e%0d zlo", edge_no), zlo, m_zlo);
      checkOutput($sformatf("e%0d zhi", edge_no), zhi, m_zhi);
      checkOutput($sformatf("e%0d div_by_zero", edge_no), W'(dbz), W'(m_dbz));
      checkOutput($sformatf("e%0d illegal_op", edge_no), W'(ill), W'(m_ill));
    end
  end

  task automatic applyStimulus(input logic [11:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    control = c; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  int busy_seen;

  task automatic waitDone(output int lat);
    lat = 0;
    busy_seen = 0;
    forever begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (done) break;
      if (busy) busy_seen++;
      if (lat >= 100) begin
        tests++; fails++;
        $display("[TB] FAIL waitDone timeout: got no done want done within 100 cycles");
        break;
      end
    end
  endtask

  typedef struct {
    int op;
    logic [W-1:0] a, b, lo, hi;
    bit dz;
    int lat;
  } vec_t;

  vec_t vq[$];

  initial begin
    int lat, dcount;
    logic [11:0] c;
    #200000;
    $display("[TB] FAIL watchdog: got hang want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, dcount;
    logic [11:0] c;
    clr = 1'b1; start = 1'b0; control = '0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    checkOutput("reset zlo", zlo, 0);
    checkOutput("reset zhi", zhi, 0);
    checkOutput("reset busy", W'(busy), 0);
    checkOutput("reset done", W'(done), 0);

    vq.push_back('{OP_ADD, 32'd7,         32'd5,         32'd12,        32'd0,         0, 1});
    vq.push_back('{OP_SUB, 32'd5,         32'd7,         32'hFFFFFFFE,  32'd0,         0, 1});
    vq.push_back('{OP_NEG, 32'd1,         32'd0,         32'hFFFFFFFF,  32'd0,         0, 1});
    vq.push_back('{OP_NOT, 32'h0F0F0000,  32'd0,         32'hF0F0FFFF,  32'd0,         0, 1});
    vq.push_back('{OP_AND, 32'hF0F0,      32'hFF00,      32'hF000,      32'd0,         0, 1});
    vq.push_back('{OP_OR,  32'hF0F0,      32'h0F00,      32'hFFF0,      32'd0,         0, 1});
    vq.push_back('{OP_SHR, 32'h80000000,  32'd31,        32'd1,         32'd0,         0, 1});
    vq.push_back('{OP_SHL, 32'd3,         32'd4,         32'h30,        32'd0,         0, 1});
    vq.push_back('{OP_SHL, 32'd1,         32'd40,        32'd0,         32'd0,         0, 1});
    vq.push_back('{OP_ROL, 32'h80000001,  32'd33,        32'd3,         32'd0,         0, 1});
    vq.push_back('{OP_ROR, 32'd1,         32'd0,         32'd1,         32'd0,         0, 1});
    vq.push_back('{OP_ROR, 32'd1,         32'd1,         32'h80000000,  32'd0,         0, 1});
    vq.push_back('{OP_MUL, 32'hFFFFFFFD,  32'd7,         32'hFFFFFFEB,  32'hFFFFFFFF,  0, 33});
    vq.push_back('{OP_MUL, 32'h10000,     32'h10000,     32'd0,         32'd1,         0, 33});
    vq.push_back('{OP_MUL, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'd1,         32'd0,         0, 33});
    vq.push_back('{OP_DIV, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  0, 33});
    vq.push_back('{OP_DIV, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         0, 33});
    vq.push_back('{OP_DIV, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         0, 33});
    vq.push_back('{OP_DIV, 32'd100,       32'd7,         32'd14,        32'd2,         0, 33});
    vq.push_back('{OP_DIV, 32'd9,         32'd0,         32'hFFFFFFFF,  32'd9,         1, 1});

    foreach (vq[i]) begin
      c = 12'(1) << vq[i].op;
      applyStimulus(c, vq[i].a, vq[i].b);
      waitDone(lat);
      checkOutput($sformatf("v%0d latency", i), lat, vq[i].lat);
      checkOutput($sformatf("v%0d busy cycles", i), busy_seen, vq[i].lat - 1);
      checkOutput($sformatf("v%0d zlo", i), zlo, vq[i].lo);
      checkOutput($sformatf("v%0d zhi", i), zhi, vq[i].hi);
      checkOutput($sformatf("v%0d div_by_zero", i), W'(dbz), W'(vq[i].dz));
      @(posedge clk); #2;
    end

    // A start raised while a divide is running must be dropped.
    applyStimulus(12'(1) << OP_DIV, 32'd100, 32'd7);
    repeat (3) @(posedge clk);
    #2;
    applyStimulus(12'(1) << OP_ADD, 32'd1, 32'd1);
    waitDone(lat);
    checkOutput("ignored start latency", lat, 29);
    checkOutput("ignored start zlo", zlo, 32'd14);
    checkOutput("ignored start zhi", zhi, 32'd2);
    dcount = 0;
    repeat (3) begin @(negedge clk); if (done) dcount++; end
    checkOutput("ignored start no extra done", dcount, 0);

    // clr in the middle of a divide aborts it silently.
    applyStimulus(12'(1) << OP_DIV, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    #2 clr = 1'b1;
    @(posedge clk); #2 clr = 1'b0;
    checkOutput("abort busy", W'(busy), 0);
    checkOutput("abort zlo", zlo, 0);
    checkOutput("abort zhi", zhi, 0);
    dcount = 0;
    repeat (40) begin @(negedge clk); if (done) dcount++; end
    checkOutput("abort no done", dcount, 0);

    applyStimulus(12'(1) << OP_ADD, 32'd7, 32'd5);
    waitDone(lat);
    checkOutput("post abort add latency", lat, 1);
    checkOutput("post abort add zlo", zlo, 32'd12);

    applyStimulus(12'h003, 32'd1, 32'd2);
    waitDone(lat);
    checkOutput("illegal latency", lat, 1);
    checkOutput("illegal flag", W'(ill), 1);
    checkOutput("illegal zlo held", zlo, 32'd12);
    checkOutput("illegal div_by_zero", W'(dbz), 0);
    applyStimulus(12'h000, 32'd1, 32'd2);
    waitDone(lat);
    checkOutput("zero control flag", W'(ill), 1);
    checkOutput("zero control zlo held", zlo, 32'd12);

    // New request issued in the very cycle done is high.
    applyStimulus(12'(1) << OP_MUL, 32'h10000, 32'h10000);
    waitDone(lat);
    checkOutput("b2b mul zhi", zhi, 32'd1);
    applyStimulus(12'(1) << OP_ADD, 32'd2, 32'd3);
    waitDone(lat);
    checkOutput("b2b add latency", lat, 1);
    checkOutput("b2b add zlo", zlo, 32'd5);
    checkOutput("b2b add zhi", zhi, 32'd0);
    checkOutput("b2b illegal cleared", W'(ill), 0);

    repeat (2) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
